// File: rtl/jt49_div_meas.sv
// Period meter for jt49 divider outputs: counts cen ticks between toggles of sig and
// reports each period over a valid/ready port. Define JT49_MEAS_FULL_EN to measure full cycles.
module jt49_div_meas #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             sig,
  output logic [WIDTH:0]   period,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             stopped
);

`ifdef JT49_MEAS_FULL_EN
  localparam int CW = WIDTH + 1;
`else
  localparam int CW = WIDTH;
`endif
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sig_q;
  logic [WIDTH:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;
  logic          stopped_q, stopped_d;
  logic          tick_edge;
  logic          emit;
  logic [CW-1:0] emit_val;
  logic          xfer;

  // In full-cycle mode falling edges are ordinary counting ticks
`ifdef JT49_MEAS_FULL_EN
  assign tick_edge = cen & sig & ~sig_q;
`else
  assign tick_edge = cen & (sig ^ sig_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stopped_d = stopped_q;
    emit      = 1'b0;
    emit_val  = '0;
    if (cen) begin
      case (state_q)
        IDLE: begin
          if (tick_edge) begin
            state_d   = RUN;
            cnt_d     = ONE;
            stopped_d = 1'b0;
          end
        end
        RUN: begin
          if (tick_edge) begin
            emit     = 1'b1;
            emit_val = cnt_q;
            cnt_d    = ONE;
          end else if (cnt_q != MAX) begin
            cnt_d = cnt_q + ONE;
          end else begin
            // Timeout: report a zero period and wait for the signal to move again
            emit      = 1'b1;
            emit_val  = '0;
            stopped_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign xfer = valid_q & ready;

  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (emit) begin
`ifdef JT49_MEAS_FULL_EN
      period_d = emit_val;
`else
      period_d = {1'b0, emit_val};
`endif
      valid_d = 1'b1;
      if (xfer) begin
        overrun_d = 1'b0;
      end else if (valid_q) begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= ONE;
      sig_q     <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (cen) begin
        sig_q <= sig;
      end
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stopped_q <= stopped_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign stopped = stopped_q;

endmodule

// File: tb/tb_jt49_div_meas.sv
// Scoreboard bench for jt49_div_meas: drives divider-like square waves and compares every
// transferred period against values queued when the stimulus was generated.
module tb_jt49_div_meas;

  localparam int WIDTH = 12;
`ifdef JT49_MEAS_FULL_EN
  localparam int STEP = 2;
  localparam int MAXC = (1 << (WIDTH + 1)) - 1;
`else
  localparam int STEP = 1;
  localparam int MAXC = (1 << WIDTH) - 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic sig = 1'b0;
  logic ready = 1'b1;
  logic [WIDTH:0] period;
  logic valid;
  logic overrun;
  logic stopped;

  int unsigned sbQ[$];
  int checks = 0;
  int errors = 0;

  jt49_div_meas #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .sig     (sig),
    .period  (period),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun),
    .stopped (stopped)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change shortly after the active edge and are sampled on the next one
  task automatic applyStimulus(input logic c, input logic s);
    @(posedge clk);
    #2;
    cen = c;
    sig = s;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cen = 1'b0;
    sig = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    sbQ.delete();
    @(negedge clk);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_stopped", stopped, 0);
  endtask

  // Square wave with half-period p ticks; cen pulses once every gap clocks
  task automatic runTone(input int p, input int nRes, input int gap, input bit pushEn);
    for (int k = 0; k <= nRes * STEP; k++) begin
      for (int j = 0; j < p; j++) begin
        if (j == 0) begin
          if (pushEn && k > 0 && (k % STEP) == 0) sbQ.push_back(p * STEP);
          applyStimulus(1'b1, ~sig);
        end else begin
          applyStimulus(1'b1, sig);
        end
        repeat (gap - 1) applyStimulus(1'b0, sig);
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    applyStimulus(1'b0, sig);
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drain"}, sbQ.size(), 0);
    sbQ.delete();
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    int unsigned expVal;
    logic [31:0] pending;
    if (rst_n && valid && ready) begin
      pending = (sbQ.size() > 0) ? 32'd1 : 32'd0;
      checkOutput("sb_pending", pending, 1);
      if (sbQ.size() > 0) begin
        expVal = sbQ.pop_front();
        checkOutput("period", period, expVal);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // P=5, cen every clock
    doReset();
    runTone(5, 5, 1, 1'b1);
    waitDrain("p5");
    checkOutput("p5_stopped", stopped, 0);

    // P=1 with cen every third clock
    doReset();
    runTone(1, 7, 3, 1'b1);
    waitDrain("p1");
    checkOutput("p1_stopped", stopped, 0);

    // Two results while ready is low: only the last survives, overrun flags the loss
    doReset();
    ready = 1'b0;
    runTone(7, 2, 1, 1'b0);
    applyStimulus(1'b0, sig);
    @(negedge clk);
    checkOutput("ovr_valid", valid, 1);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_period", period, 7 * STEP);
    sbQ.push_back(7 * STEP);
    @(posedge clk);
    #2;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ovr_valid_after", valid, 0);
    checkOutput("ovr_flag_after", overrun, 0);
    checkOutput("ovr_drain", sbQ.size(), 0);

    // Timeout exactly MAXC ticks after the last counted edge
    doReset();
    runTone(3, 2, 1, 1'b1);
    for (int i = 2; i < MAXC - 1; i++) applyStimulus(1'b1, sig);
    applyStimulus(1'b0, sig);
    @(negedge clk);
    checkOutput("to_not_yet", stopped, 0);
    checkOutput("to_idle_q", sbQ.size(), 0);
    sbQ.push_back(0);
    applyStimulus(1'b1, sig);
    applyStimulus(1'b0, sig);
    @(negedge clk);
    checkOutput("to_stopped", stopped, 1);
    checkOutput("to_valid", valid, 1);
    repeat (20) applyStimulus(1'b1, sig);
    applyStimulus(1'b0, sig);
    @(negedge clk);
    checkOutput("to_hold", stopped, 1);
    applyStimulus(1'b1, ~sig);
`ifdef JT49_MEAS_FULL_EN
    applyStimulus(1'b1, ~sig);
`endif
    applyStimulus(1'b0, sig);
    repeat (2) @(negedge clk);
    checkOutput("to_rearm_stopped", stopped, 0);
    checkOutput("to_rearm_valid", valid, 0);

    // An edge landing exactly at cnt==MAX reports MAX
    doReset();
    applyStimulus(1'b1, ~sig);
`ifdef JT49_MEAS_FULL_EN
    for (int i = 0; i < MAXC - 2; i++) applyStimulus(1'b1, sig);
    applyStimulus(1'b1, ~sig);
`else
    for (int i = 0; i < MAXC - 1; i++) applyStimulus(1'b1, sig);
`endif
    sbQ.push_back(MAXC);
    applyStimulus(1'b1, ~sig);
    waitDrain("maxedge");
    checkOutput("maxedge_stopped", stopped, 0);

    // Reset mid-count discards the partial measurement
    doReset();
    runTone(9, 1, 1, 1'b1);
    waitDrain("p9a");
    repeat (4) applyStimulus(1'b1, sig);
    doReset();
    runTone(9, 2, 1, 1'b1);
    waitDrain("p9b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
